// File: rtl/adc0809_ctrl_pkg.sv
// Shared definitions for the ADC0809 read path: state encodings, default timing
// constants and a counter-width helper.
package adc0809_ctrl_pkg;

   localparam int DATA_W = 8;
   localparam int CH_W   = 3;

   // Defaults for the 100 MHz system clock
   localparam int CLK_HALF_DEF    = 100;
   localparam int PULSE_CYC_DEF   = 50;
   localparam int TIMEOUT_CYC_DEF = 20000;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_STRT    = 3'd2,
      S_WAIT_LO = 3'd3,
      S_WAIT_HI = 3'd4,
      S_READ    = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adc0809_ctrl_clk_gen.sv
// Free-running converter clock: toggles every CLK_HALF system cycles, 50 % duty.
module adc_clk_gen
   import adc0809_ctrl_pkg::*;
#(
   parameter int CLK_HALF = CLK_HALF_DEF
) (
   input  logic clk,
   input  logic rst,
   output logic adc_clk
);

   localparam int HW = cnt_w(CLK_HALF);
   localparam logic [HW-1:0] HALF_LAST = HW'(CLK_HALF - 1);

   logic [HW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         adc_clk <= 1'b0;
      end else if (cnt == HALF_LAST) begin
         cnt     <= '0;
         adc_clk <= ~adc_clk;
      end else begin
         cnt <= cnt + HW'(1);
      end
   end

endmodule

// File: rtl/adc0809_ctrl.sv
// ADC0809 handshake controller: address setup, ALE/START pulse, EOC wait with
// timeout, OE read window and result capture.
module adc0809_ctrl
   import adc0809_ctrl_pkg::*;
#(
   parameter int CLK_HALF    = CLK_HALF_DEF,
   parameter int PULSE_CYC   = PULSE_CYC_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              conv_req,
   input  logic [CH_W-1:0]   channel,
   input  logic              adc_eoc,
   input  logic [DATA_W-1:0] adc_d,
   output logic              adc_clk,
   output logic [CH_W-1:0]   adc_addr,
   output logic              adc_ale,
   output logic              adc_start,
   output logic              adc_oe,
   output logic [DATA_W-1:0] data,
   output logic              data_valid,
   output logic              busy,
   output logic              timeout
);

   localparam int PW = cnt_w(PULSE_CYC);
   localparam int TW = cnt_w(TIMEOUT_CYC);
   localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYC - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);

   state_t        state;
   logic [PW-1:0] pcnt;
   logic [TW-1:0] tcnt;
   logic          eoc_m;
   logic          eoc_s;

   adc_clk_gen #(
      .CLK_HALF (CLK_HALF)
   ) u_clk_gen (
      .clk     (clk),
      .rst     (rst),
      .adc_clk (adc_clk)
   );

   // EOC comes from the converter's own clock domain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         eoc_m <= 1'b0;
         eoc_s <= 1'b0;
      end else begin
         eoc_m <= adc_eoc;
         eoc_s <= eoc_m;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         pcnt       <= '0;
         tcnt       <= '0;
         adc_addr   <= '0;
         adc_ale    <= 1'b0;
         adc_start  <= 1'b0;
         adc_oe     <= 1'b0;
         data       <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         timeout    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (conv_req) begin
                  adc_addr <= channel;
                  pcnt     <= '0;
                  busy     <= 1'b1;
                  state    <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (pcnt == PULSE_LAST) begin
                  pcnt      <= '0;
                  adc_ale   <= 1'b1;
                  adc_start <= 1'b1;
                  state     <= S_STRT;
               end else begin
                  pcnt <= pcnt + PW'(1);
               end
            end
            S_STRT: begin
               if (pcnt == PULSE_LAST) begin
                  adc_ale   <= 1'b0;
                  adc_start <= 1'b0;
                  tcnt      <= '0;
                  state     <= S_WAIT_LO;
               end else begin
                  pcnt <= pcnt + PW'(1);
               end
            end
            // Both EOC waits share tcnt; it restarts on entry to each
            S_WAIT_LO: begin
               if (!eoc_s) begin
                  tcnt  <= '0;
                  state <= S_WAIT_HI;
               end else if (tcnt == TMO_LAST) begin
                  timeout <= 1'b1;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            S_WAIT_HI: begin
               if (eoc_s) begin
                  pcnt   <= '0;
                  adc_oe <= 1'b1;
                  state  <= S_READ;
               end else if (tcnt == TMO_LAST) begin
                  timeout <= 1'b1;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            S_READ: begin
               if (pcnt == PULSE_LAST) begin
                  data       <= adc_d;
                  adc_oe     <= 1'b0;
                  data_valid <= 1'b1;
                  state      <= S_DONE;
               end else begin
                  pcnt <= pcnt + PW'(1);
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               adc_ale   <= 1'b0;
               adc_start <= 1'b0;
               adc_oe    <= 1'b0;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
